i2c_slave_tx_controller: RTL
============================

Name: i2c_slave_tx_controller

Overview:
Sequences the slave-side transmit path for a master-read transaction. After the address stage decodes a read, it fetches bytes from a byte-wide source and feeds each one MSB-first to I2C_slave_write_byte over its go/data/load/finish handshake. After each byte it runs the ACK-receive submodule and continues on ACK or ends on NACK. It sits between the slave top-level FSM (start/abort) and the bit-level write-byte and read-ack modules.

Parameters:
FILLER_BYTE, 8'hFF, byte sent when the source is empty at fetch time (underrun)
CNT_WIDTH, 8, width of the transmitted-byte counter (saturating)

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  1-cycle pulse: read transaction granted, begin transmitting
abort  input  1  level or pulse: STOP/repeated START seen; return to IDLE
tx_valid  input  1  source has a byte
tx_byte  input  8  byte to send
tx_ready  output  1  1-cycle pulse: tx_byte consumed this cycle
wb_go  output  1  go to I2C_slave_write_byte; held high for the whole byte
wb_data  output  1  current bit to write (shift register bit 7)
wb_load  input  1  write-byte consumed current bit; advance to next
wb_finish  input  1  write-byte completed 8 bits
ack_go  output  1  go to ACK-receive submodule; held until ack_finish
ack_finish  input  1  ACK slot sampled
ack_bit  input  1  sampled SDA in ACK slot (0=ACK, 1=NACK)
busy  output  1  high in any state except IDLE
byte_count  output  CNT_WIDTH  bytes acknowledged-or-nacked this transaction
underrun  output  1  sticky: FILLER_BYTE was sent; cleared on start
done  output  1  1-cycle pulse: transaction ended by NACK
proto_err  output  1  sticky: more than 8 wb_load pulses in one byte; cleared on start

Behaviour:
- Reset (synchronous, active-high) overrides everything. State=IDLE. All outputs 0. shreg=0. byte_count=0.
- IDLE: start -> FETCH. Clear byte_count, underrun and proto_err. start is ignored outside IDLE.
- FETCH (1 cycle): if tx_valid, load shreg<=tx_byte and pulse tx_ready. Otherwise load shreg<=FILLER_BYTE, set underrun and leave tx_ready low. Reset load counter to 0. Go to SEND.
- SEND: wb_go=1, wb_data=shreg[7]. On each wb_load: shreg<={shreg[6:0],1'b0} and increment the 4-bit load counter. A wb_load arriving when the counter is already 8 sets proto_err and does not shift. On wb_finish: drop wb_go the next cycle and go to GET_ACK.
  - wb_go falls only via the finish transition, matching the write-byte go-level contract.
- GET_ACK: ack_go=1. On ack_finish: byte_count increments, saturating at all-ones.
  - ack_bit=0: go to FETCH (next byte).
  - ack_bit=1: pulse done, go to IDLE.
- abort in any non-IDLE state takes priority over all other events in that cycle. Next state is IDLE, and wb_go, ack_go and tx_ready go low the next cycle. No done pulse. byte_count holds its value until the next start.
- wb_finish and wb_load in the same cycle: the shift is performed, then the state transitions.
- wb_finish outside SEND and ack_finish outside GET_ACK are ignored.
- Latency: start -> wb_go high = 2 cycles (FETCH, then SEND registered). wb_finish -> ack_go high = 1 cycle. ack_finish(ACK) -> next wb_go high = 2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, SEND, GET_ACK), ACK/NACK bit constants, default FILLER_BYTE.
- One natural sub-module: i2c_tx_shifter (8-bit load/shift register with load counter and overflow flag), instantiated once. The FSM and counters stay in the top.

Test Plan:
- Single byte, NACK: source holds 8'hA5, start, bench write-byte model captures bits on load, ack_bit=1 -> captured 8'hA5, exactly one tx_ready, done pulse, byte_count=1, busy low afterwards.
- Four bytes, ACK,ACK,ACK,NACK: source 13,57,9B,DF -> captured 13,57,9B,DF in order, byte_count=4, one done pulse, underrun=0.
- Underrun: tx_valid=0 at second FETCH, master ACKs first byte -> second byte captured 8'hFF, underrun=1, no tx_ready for that byte.
- Abort mid-byte: abort after 3 wb_load pulses of 8'hC3 -> next cycle wb_go=0, state IDLE, no done, byte_count=0; a following start with 8'h3C transmits 3C cleanly.
- Protocol error: 9 wb_load pulses before wb_finish -> proto_err=1, shreg not shifted on the 9th pulse; a new start clears proto_err.
- Reset mid-GET_ACK: assert reset while ack_go=1 -> next edge all outputs 0, state IDLE. Start issued in the same cycle as reset is ignored.

Source files
------------

// File: rtl/i2c_slave_tx_controller_pkg.sv
// Shared definitions for the I2C slave transmit controller.
//   tx_state_e          : controller FSM states
//   ACK_BIT / NACK_BIT  : SDA level sampled in the acknowledge slot
//   DEFAULT_FILLER_BYTE : byte sent when the source underruns
//   BITS_PER_BYTE       : shifts allowed per byte before a protocol error
package i2c_slave_tx_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_GET_ACK
  } tx_state_e;

  localparam logic        ACK_BIT             = 1'b0;
  localparam logic        NACK_BIT            = 1'b1;
  localparam logic [7:0]  DEFAULT_FILLER_BYTE = 8'hFF;
  localparam int unsigned BITS_PER_BYTE       = 8;

endpackage

// File: rtl/i2c_slave_tx_controller_if.sv
// Handshake bundle between the transmit controller and its environment
// (slave top FSM, byte source, write-byte and ACK-receive submodules).
//   slave  : view used by i2c_slave_tx_controller
//   master : view used by whatever drives the controller
interface i2c_slave_tx_controller_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic                 tx_valid;
  logic [7:0]           tx_byte;
  logic                 tx_ready;
  logic                 wb_go;
  logic                 wb_data;
  logic                 wb_load;
  logic                 wb_finish;
  logic                 ack_go;
  logic                 ack_finish;
  logic                 ack_bit;
  logic                 busy;
  logic [CNT_WIDTH-1:0] byte_count;
  logic                 underrun;
  logic                 done;
  logic                 proto_err;

  modport slave (
    input  start, abort, tx_valid, tx_byte, wb_load, wb_finish, ack_finish, ack_bit,
    output tx_ready, wb_go, wb_data, ack_go, busy, byte_count, underrun, done, proto_err
  );

  modport master (
    output start, abort, tx_valid, tx_byte, wb_load, wb_finish, ack_finish, ack_bit,
    input  tx_ready, wb_go, wb_data, ack_go, busy, byte_count, underrun, done, proto_err
  );

endinterface

// File: rtl/i2c_tx_shifter.sv
// 8-bit load/shift register feeding the write-byte submodule MSB-first.
//   clock, reset : system clock, synchronous active-high reset
//   load_i       : parallel load of load_val_i, clears the shift counter
//   load_val_i   : byte to load
//   shift_i      : shift left one bit (write-byte consumed current bit)
//   msb_o        : current bit (shreg[7])
//   overflow_o   : shift requested after all 8 bits were already consumed
module i2c_tx_shifter
  import i2c_slave_tx_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       shift_i,
  output logic       msb_o,
  output logic       overflow_o
);

  logic [7:0] shreg_q, shreg_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    overflow_o = 1'b0;
    if (load_i) begin
      shreg_d = load_val_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      // A ninth shift is flagged and leaves the register untouched.
      if (cnt_q == 4'(BITS_PER_BYTE)) begin
        overflow_o = 1'b1;
      end else begin
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb_o = shreg_q[7];

endmodule

// File: rtl/i2c_slave_tx_controller.sv
// Slave-side transmit sequencer for an I2C master-read transaction.
// Fetches bytes from a byte source, hands each one bit-serially to the
// write-byte submodule, then runs the ACK-receive submodule and either
// continues (ACK) or ends the transaction (NACK).
//   clock, reset      : system clock, synchronous active-high reset
//   bus (slave)       : start/abort from the slave FSM, tx_* byte source,
//                       wb_* write-byte handshake, ack_* ACK handshake,
//                       status busy/byte_count/underrun/done/proto_err
// Every output comes from a register; nothing is combinational from inputs.
module i2c_slave_tx_controller
  import i2c_slave_tx_controller_pkg::*;
#(
  parameter logic [7:0]  FILLER_BYTE = DEFAULT_FILLER_BYTE,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input logic                        clock,
  input logic                        reset,
  i2c_slave_tx_controller_if.slave   bus
);

  tx_state_e            state_q, state_d;
  logic                 wb_go_q, ack_go_q, busy_q;
  logic                 tx_ready_q, tx_ready_d;
  logic                 done_q, done_d;
  logic                 underrun_q, underrun_d;
  logic                 proto_err_q, proto_err_d;
  logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;

  logic       aborting;
  logic       load_en;
  logic [7:0] load_val;
  logic       shift_en;
  logic       shreg_msb;
  logic       overflow;

  assign aborting = (state_q != ST_IDLE) && bus.abort;

  // Shifter controls are kept outside the FSM block so the overflow flag
  // coming back from the shifter does not form a loop through it.
  assign load_en  = (state_q == ST_FETCH) && !bus.abort;
  assign load_val = bus.tx_valid ? bus.tx_byte : FILLER_BYTE;
  assign shift_en = (state_q == ST_SEND) && bus.wb_load && !bus.abort;

  i2c_tx_shifter u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load_en),
    .load_val_i (load_val),
    .shift_i    (shift_en),
    .msb_o      (shreg_msb),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d      = state_q;
    tx_ready_d   = 1'b0;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    proto_err_d  = proto_err_q;
    byte_count_d = byte_count_q;
    if (aborting) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d      = ST_FETCH;
            byte_count_d = '0;
            underrun_d   = 1'b0;
            proto_err_d  = 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.tx_valid) tx_ready_d = 1'b1;
          else              underrun_d = 1'b1;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (overflow)      proto_err_d = 1'b1;
          if (bus.wb_finish) state_d     = ST_GET_ACK;
        end
        ST_GET_ACK: begin
          if (bus.ack_finish) begin
            if (byte_count_q != '1) byte_count_d = byte_count_q + CNT_WIDTH'(1);
            if (bus.ack_bit == ACK_BIT) begin
              state_d = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wb_go_q      <= 1'b0;
      ack_go_q     <= 1'b0;
      busy_q       <= 1'b0;
      tx_ready_q   <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      // Go levels and busy follow the state being entered, so they rise and
      // fall on the same edge as the transition that causes them.
      wb_go_q      <= (state_d == ST_SEND);
      ack_go_q     <= (state_d == ST_GET_ACK);
      busy_q       <= (state_d != ST_IDLE);
      tx_ready_q   <= tx_ready_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      proto_err_q  <= proto_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.wb_go      = wb_go_q;
  assign bus.wb_data    = shreg_msb & wb_go_q;
  assign bus.ack_go     = ack_go_q;
  assign bus.busy       = busy_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.byte_count = byte_count_q;

endmodule
